// File: rtl/uart_pkg.sv
// Shared UART definitions for the word transmitter and the receive-side buffer.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = BITS_PER_BYTE * BYTES_PER_WORD;

endpackage

// File: rtl/uart_word_tx_if.sv
// Word-side port bundle between the execute stage and the UART word transmitter.
interface uart_word_tx_if;
  import uart_pkg::*;

  logic [WORD_WIDTH-1:0] data_in;
  logic                  write_enable;
  logic                  full;
  logic                  idle;
  logic                  overflow;

  modport master (
    output data_in,
    output write_enable,
    input  full,
    input  idle,
    input  overflow
  );

  modport slave (
    input  data_in,
    input  write_enable,
    output full,
    output idle,
    output overflow
  );

endinterface

// File: rtl/uart_word_tx_word_fifo.sv
// Synchronous word FIFO with registered full/empty and a combinational head word.
module word_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** AW;
  localparam int CW    = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [AW:0]      count_next;

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign wr_ok      = wr_en && !full;
  assign rd_ok      = rd_en && !empty;
  assign count_next = count + CW'(wr_ok) - CW'(rd_ok);
  assign rd_data    = mem[rd_ptr];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_word_tx.sv
// UART word transmitter: buffers 32-bit words and sends each as four
// big-endian 8N1 bytes with an integrated baud counter.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic           CLK,
  input  logic           reset,
  uart_word_tx_if.slave  bus,
  output logic           UART_TX
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(BITS_PER_BYTE);
  localparam int BYTE_W = $clog2(BYTES_PER_WORD);
  localparam int CW     = FIFO_AW + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_BYTE - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_WORD - 1);

  tx_state_t              state, state_next;
  logic [BAUD_W-1:0]      baud, baud_next;
  logic [BIT_W-1:0]       bit_idx, bit_next;
  logic [BYTE_W-1:0]      byte_idx, byte_next;
  logic [WORD_WIDTH-1:0]  shreg, shreg_next;
  logic [BITS_PER_BYTE-1:0] cur_byte;
  logic                   tx_next;
  logic                   baud_done;
  logic                   pop;
  logic                   wr_ok;
  logic [WORD_WIDTH-1:0]  fifo_data;
  logic [FIFO_AW:0]       fifo_count;
  logic [FIFO_AW:0]       count_next;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   idle_q;
  logic                   overflow_q;

  word_fifo #(
    .WIDTH (WORD_WIDTH),
    .AW    (FIFO_AW)
  ) fifo (
    .CLK     (CLK),
    .reset   (reset),
    .wr_en   (bus.write_enable),
    .wr_data (bus.data_in),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_done  = (baud == BAUD_LAST);
  assign wr_ok      = bus.write_enable && !fifo_full;
  assign count_next = fifo_count + CW'(wr_ok) - CW'(pop);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_next;
      baud     <= baud_next;
      bit_idx  <= bit_next;
      byte_idx <= byte_next;
      shreg    <= shreg_next;
    end
  end

  // The current byte always sits in the top of shreg; STOP shifts the next one up.
  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    byte_next  = byte_idx;
    shreg_next = shreg;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_next = fifo_data;
          byte_next  = '0;
          bit_next   = '0;
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == BIT_LAST) state_next = STOP;
          else                     bit_next   = bit_idx + 1'b1;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          if (byte_idx != BYTE_LAST) begin
            byte_next  = byte_idx + 1'b1;
            shreg_next = shreg << BITS_PER_BYTE;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is computed from the upcoming state so UART_TX can be a flop.
  always_comb begin
    cur_byte = shreg_next[WORD_WIDTH-1 -: BITS_PER_BYTE];
    tx_next  = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = cur_byte[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      UART_TX    <= 1'b1;
      idle_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      UART_TX <= tx_next;
      idle_q  <= (count_next == '0) && (state_next == IDLE);
      if (bus.write_enable && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign bus.full     = fifo_full;
  assign bus.idle     = idle_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: two instances (4 and 2 clocks per bit, depth 4).
module tb_uart_word_tx;
  import uart_pkg::*;

  localparam int LOG_N = 8192;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic tx_a;
  logic tx_b;

  uart_word_tx_if bus_a ();
  uart_word_tx_if bus_b ();

  uart_word_tx #(.CLKS_PER_BIT(4), .FIFO_AW(2)) dut_a (
    .CLK     (CLK),
    .reset   (reset),
    .bus     (bus_a),
    .UART_TX (tx_a)
  );

  uart_word_tx #(.CLKS_PER_BIT(2), .FIFO_AW(2)) dut_b (
    .CLK     (CLK),
    .reset   (reset),
    .bus     (bus_b),
    .UART_TX (tx_b)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic log_a [LOG_N];
  logic log_b [LOG_N];

  // Line history: entry i holds UART_TX just after clock edge i.
  always begin
    @(posedge CLK);
    #1;
    if (cyc < LOG_N) begin
      log_a[cyc] = tx_a;
      log_b[cyc] = tx_b;
    end
    cyc = cyc + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic int now_idx();
    return cyc - 1;
  endfunction

  task automatic wait_until(input int idx);
    while (cyc - 1 < idx) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  function automatic logic [79:0] expected_byte(input logic [7:0] bv, input int cpb);
    logic [79:0] e;
    int pos;
    e = '0;
    for (int k = 0; k < 10 * cpb; k++) begin
      pos = k / cpb;
      if (pos == 0)      e[k] = 1'b0;
      else if (pos == 9) e[k] = 1'b1;
      else               e[k] = bv[pos-1];
    end
    return e;
  endfunction

  function automatic logic [79:0] logged_byte(input int sel, input int first, input int cpb);
    logic [79:0] g;
    g = '0;
    for (int k = 0; k < 10 * cpb; k++)
      g[k] = (sel == 0) ? log_a[first+k] : log_b[first+k];
    return g;
  endfunction

  task automatic test_reset();
    logic bad_tx, bad_idle, bad_full, bad_ovf;
    bad_tx = 0; bad_idle = 0; bad_full = 0; bad_ovf = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (tx_a !== 1'b1 || tx_b !== 1'b1) bad_tx = 1;
      if (bus_a.idle !== 1'b1 || bus_b.idle !== 1'b1) bad_idle = 1;
      if (bus_a.full !== 1'b0 || bus_b.full !== 1'b0) bad_full = 1;
      if (bus_a.overflow !== 1'b0 || bus_b.overflow !== 1'b0) bad_ovf = 1;
      tick();
    end
    n_cmp++; if (bad_tx !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_tx line left idle-high got %b need 0 violations", bad_tx); end
    n_cmp++; if (bad_idle !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_idle got violation %b need 0", bad_idle); end
    n_cmp++; if (bad_full !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_full got violation %b need 0", bad_full); end
    n_cmp++; if (bad_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_overflow got violation %b need 0", bad_ovf); end
  endtask

  task automatic test_single_word();
    int n, s;
    logic [31:0] w;
    logic [79:0] got, exp;
    w = 32'h41424344;
    n = now_idx();
    bus_a.data_in = w;
    bus_a.write_enable = 1'b1;
    tick();
    bus_a.write_enable = 1'b0;
    n_cmp++; if (bus_a.idle !== 1'b0) begin n_bad++; $display("[TB] FAIL single_idle_after_accept got %b need 0", bus_a.idle); end
    n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("[TB] FAIL single_line_before_start got %b need 1", tx_a); end
    s = n + 2;
    wait_until(s + 159);
    for (int b = 0; b < 4; b++) begin
      got = logged_byte(0, s + b * 40, 4);
      exp = expected_byte(w[8*(3-b) +: 8], 4);
      n_cmp++; if (got !== exp) begin n_bad++; $display("[TB] FAIL single_byte%0d got %h need %h", b, got, exp); end
    end
    n_cmp++; if (bus_a.idle !== 1'b0) begin n_bad++; $display("[TB] FAIL single_idle_last_cycle got %b need 0", bus_a.idle); end
    tick();
    n_cmp++; if (bus_a.idle !== 1'b1) begin n_bad++; $display("[TB] FAIL single_idle_after_frame got %b need 1", bus_a.idle); end
  endtask

  task automatic test_back_to_back();
    int n, s;
    logic [31:0] w;
    logic [79:0] got, exp;
    n = now_idx();
    for (int i = 0; i < 6; i++) begin
      bus_a.data_in = 32'(i + 1);
      bus_a.write_enable = 1'b1;
      tick();
      n_cmp++; if (bus_a.full !== (i >= 4)) begin n_bad++; $display("[TB] FAIL b2b_full_w%0d got %b need %b", i + 1, bus_a.full, (i >= 4)); end
      n_cmp++; if (bus_a.overflow !== (i == 5)) begin n_bad++; $display("[TB] FAIL b2b_overflow_w%0d got %b need %b", i + 1, bus_a.overflow, (i == 5)); end
    end
    bus_a.write_enable = 1'b0;
    s = n + 2;
    wait_until(s + 4 * 161 + 159);
    for (int k = 0; k < 5; k++) begin
      w = 32'(k + 1);
      for (int b = 0; b < 4; b++) begin
        got = logged_byte(0, s + k * 161 + b * 40, 4);
        exp = expected_byte(w[8*(3-b) +: 8], 4);
        n_cmp++; if (got !== exp) begin n_bad++; $display("[TB] FAIL b2b_word%0d_byte%0d got %h need %h", k + 1, b, got, exp); end
      end
    end
    tick();
    n_cmp++; if (bus_a.idle !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_idle_after_burst got %b need 1", bus_a.idle); end
    repeat (10) tick();
    n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_dropped_word_sent line got %b need 1", tx_a); end
  endtask

  task automatic test_overflow_on_pop();
    int n, s;
    logic [31:0] w;
    logic [79:0] got, exp;
    do_reset();
    n = now_idx();
    for (int i = 0; i < 5; i++) begin
      bus_a.data_in = 32'hC0DE0000 + 32'(i);
      bus_a.write_enable = 1'b1;
      tick();
    end
    bus_a.write_enable = 1'b0;
    s = n + 2;
    wait_until(s + 160);
    n_cmp++; if (bus_a.full !== 1'b1) begin n_bad++; $display("[TB] FAIL pop_full_before got %b need 1", bus_a.full); end
    n_cmp++; if (bus_a.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL pop_overflow_before got %b need 0", bus_a.overflow); end
    bus_a.data_in = 32'hDEADBEEF;
    bus_a.write_enable = 1'b1;
    tick();
    bus_a.write_enable = 1'b0;
    n_cmp++; if (bus_a.full !== 1'b0) begin n_bad++; $display("[TB] FAIL pop_full_after got %b need 0", bus_a.full); end
    n_cmp++; if (bus_a.overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL pop_overflow_after got %b need 1", bus_a.overflow); end
    wait_until(s + 4 * 161 + 159);
    for (int k = 0; k < 5; k++) begin
      w = 32'hC0DE0000 + 32'(k);
      for (int b = 0; b < 4; b++) begin
        got = logged_byte(0, s + k * 161 + b * 40, 4);
        exp = expected_byte(w[8*(3-b) +: 8], 4);
        n_cmp++; if (got !== exp) begin n_bad++; $display("[TB] FAIL pop_word%0d_byte%0d got %h need %h", k, b, got, exp); end
      end
    end
    tick();
    n_cmp++; if (bus_a.idle !== 1'b1) begin n_bad++; $display("[TB] FAIL pop_idle_after got %b need 1", bus_a.idle); end
  endtask

  task automatic test_reset_mid_frame();
    int n, s;
    logic [31:0] w;
    logic [79:0] got, exp;
    n = now_idx();
    bus_a.data_in = 32'hFFFF0000;
    bus_a.write_enable = 1'b1;
    tick();
    bus_a.write_enable = 1'b0;
    s = n + 2;
    wait_until(s + 90);
    n_cmp++; if (tx_a !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_data_bit got %b need 0", tx_a); end
    reset = 1'b1;
    #1;
    n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_async_line got %b need 1", tx_a); end
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (bus_a.idle !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_idle got %b need 1", bus_a.idle); end
    n_cmp++; if (bus_a.full !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_full got %b need 0", bus_a.full); end
    n_cmp++; if (bus_a.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_overflow got %b need 0", bus_a.overflow); end
    repeat (5) tick();
    n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_line_quiet got %b need 1", tx_a); end
    w = 32'h12345678;
    n = now_idx();
    bus_a.data_in = w;
    bus_a.write_enable = 1'b1;
    tick();
    bus_a.write_enable = 1'b0;
    s = n + 2;
    wait_until(s + 159);
    for (int b = 0; b < 4; b++) begin
      got = logged_byte(0, s + b * 40, 4);
      exp = expected_byte(w[8*(3-b) +: 8], 4);
      n_cmp++; if (got !== exp) begin n_bad++; $display("[TB] FAIL midrst_next_byte%0d got %h need %h", b, got, exp); end
    end
    tick();
    n_cmp++; if (bus_a.idle !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_idle_end got %b need 1", bus_a.idle); end
  endtask

  task automatic test_fast_baud();
    int n, s;
    logic [31:0] w;
    logic [79:0] got, exp;
    w = 32'hA5A5A5A5;
    n = now_idx();
    bus_b.data_in = w;
    bus_b.write_enable = 1'b1;
    tick();
    bus_b.write_enable = 1'b0;
    s = n + 2;
    wait_until(s + 79);
    n_cmp++; if (log_b[s-1] !== 1'b1) begin n_bad++; $display("[TB] FAIL fast_pre_start got %b need 1", log_b[s-1]); end
    for (int b = 0; b < 4; b++) begin
      got = logged_byte(1, s + b * 20, 2);
      exp = expected_byte(w[8*(3-b) +: 8], 2);
      n_cmp++; if (got !== exp) begin n_bad++; $display("[TB] FAIL fast_byte%0d got %h need %h", b, got, exp); end
    end
    n_cmp++; if (bus_b.idle !== 1'b0) begin n_bad++; $display("[TB] FAIL fast_idle_last_cycle got %b need 0", bus_b.idle); end
    tick();
    n_cmp++; if (bus_b.idle !== 1'b1) begin n_bad++; $display("[TB] FAIL fast_idle_after got %b need 1", bus_b.idle); end
  endtask

  initial begin
    bus_a.data_in = '0;
    bus_a.write_enable = 1'b0;
    bus_b.data_in = '0;
    bus_b.write_enable = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow_on_pop();
    test_reset_mid_frame();
    test_fast_baud();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
